multicycle_vec_controller: RTL and testbench

// - Next-generation control unit for the ARM core: multicycle FSM replacing the single-cycle decode/condlogic pair.
// - Sequences fetch/decode/execute/writeback over several cycles so instruction memory and data memory can be shared.
// - Adds vector instructions that execute one lane per cycle; VEC_LANES is parametrised.
// - Sits beside the multicycle datapath and drives all of its muxes and write strobes.

---
 rtl/arm_ctrl_pkg.sv | 98 +++++++++
 rtl/cond_unit.sv | 52 +++++
 rtl/multicycle_vec_controller.sv | 163 ++++++++++++++++
 tb/tb_multicycle_vec_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared types for the multicycle ARM controller: FSM states, mux/ALU/cond/op codes.
// No logic of its own; state_ctrl gives the unqualified Moore controls of a state.
// Pure decode helper, so there is no latency and no backpressure.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        VEXEC  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_VEC = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] SRCA_RN    = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCA_ALUO  = 2'b10;
    localparam logic [1:0] SRCB_RM    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       regw;
        logic       memw;
        logic       brw;
        logic       vecw;
        logic       use_alu;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irw = 1'b1; c.pcw = 1'b1; c.result_src = RES_ALU;
                c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR;
            end
            DECODE: begin
                c.result_src = RES_ALU; c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR;
            end
            MEMADR: c.alu_src_b = SRCB_IMM;
            MEMRD:  c.adr_src = 1'b1;
            MEMWB:  begin c.regw = 1'b1; c.result_src = RES_DATA; end
            MEMWR:  begin c.memw = 1'b1; c.adr_src = 1'b1; end
            EXECR:  c.use_alu = 1'b1;
            EXECI:  begin c.use_alu = 1'b1; c.alu_src_b = SRCB_IMM; end
            ALUWB:  c.regw = 1'b1;
            BRANCH: begin
                c.brw = 1'b1; c.result_src = RES_ALU;
                c.alu_src_a = SRCA_ALUO; c.alu_src_b = SRCB_IMM;
            end
            VEXEC:  begin c.vecw = 1'b1; c.use_alu = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Flags register {N,Z,C,V} with per-pair write gating, and CondEx evaluation.
// CondEx is combinational from Cond and the registered flags; flag writes land on the next edge.
// No backpressure: the FSM decides when flag_en is asserted.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       flag_en,
    output logic       condex
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_en && flag_w[1]) flags[3:2] <= alu_flags[3:2];
            if (flag_en && flag_w[0]) flags[1:0] <= alu_flags[1:0];
        end
    end

    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_vec_controller.sv
// Multicycle ARM control FSM with a lane-iterating vector execute state.
// Latency: branch 3, data-processing/STR 4, LDR 5, vector VEC_LANES+2 cycles.
// No backpressure; reset aborts any instruction at once and restarts at FETCH.
module multicycle_vec_controller
    import arm_ctrl_pkg::*;
#(
    parameter  int VEC_LANES = 4,
    localparam int LANE_W    = (VEC_LANES > 1) ? $clog2(VEC_LANES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [19:0]       Instr,
    input  logic [3:0]        ALUFlags,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [2:0]        ALUControl,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              VecWrite,
    output logic [LANE_W-1:0] VecLane,
    output logic              Busy
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VEC_LANES - 1);

    state_t            state, state_n;
    logic [LANE_W-1:0] lane, lane_n;
    logic              started;
    logic              vcond_q;
    logic              pcw_q, regw_q, memw_q, brw_q, vecw_q;
    logic              condex, alu_ok, is_cmp, wr_ok, flag_en;
    logic [2:0]        alu_dec;
    logic [1:0]        flag_w;
    logic              unused_regs;
    ctrl_t             c_n;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign unused_regs = ^Instr[7:0];

    always_comb begin
        alu_dec = ALU_ADD;
        alu_ok  = 1'b1;
        case (funct[4:1])
            4'b0100:          alu_dec = ALU_ADD;
            4'b0010, 4'b1010: alu_dec = ALU_SUB;
            4'b0000:          alu_dec = ALU_AND;
            4'b1100:          alu_dec = ALU_ORR;
            default:          alu_ok  = 1'b0;
        endcase
    end

    assign is_cmp = (funct[4:1] == 4'b1010);
    // Memory and branch encodings reuse Funct bits, so only ALU-driven ops are vetoed.
    assign wr_ok  = (op == OP_MEM || op == OP_BR) ? 1'b1 : alu_ok;
    assign flag_w = {funct[0] | is_cmp,
                     (funct[0] & alu_ok & (alu_dec == ALU_ADD || alu_dec == ALU_SUB)) | is_cmp};
    assign flag_en = alu_ok & ((((state == EXECR) || (state == EXECI)) & condex) |
                               ((state == VEXEC) & vcond_q));

    cond_unit u_cond (
        .clk      (clk),
        .reset    (reset),
        .cond     (cond),
        .alu_flags(ALUFlags),
        .flag_w   (flag_w),
        .flag_en  (flag_en),
        .condex   (condex)
    );

    always_comb begin
        state_n = state;
        lane_n  = lane;
        if (!started) begin
            state_n = FETCH;
        end else begin
            case (state)
                FETCH:  begin state_n = DECODE; lane_n = '0; end
                DECODE: begin
                    case (op)
                        OP_MEM:  state_n = MEMADR;
                        OP_DP:   state_n = funct[5] ? EXECI : EXECR;
                        OP_BR:   state_n = BRANCH;
                        default: state_n = VEXEC;
                    endcase
                end
                MEMADR: state_n = funct[0] ? MEMRD : MEMWR;
                MEMRD:  state_n = MEMWB;
                EXECR, EXECI: state_n = ALUWB;
                VEXEC: begin
                    if (lane == LAST_LANE) begin
                        state_n = FETCH;
                        lane_n  = '0;
                    end else begin
                        lane_n = lane + 1'b1;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    assign c_n = state_ctrl(state_n);

    // Outputs are registered from the next state, so they always describe the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            lane       <= '0;
            started    <= 1'b0;
            vcond_q    <= 1'b0;
            IRWrite    <= 1'b0;
            pcw_q      <= 1'b0;
            regw_q     <= 1'b0;
            memw_q     <= 1'b0;
            brw_q      <= 1'b0;
            vecw_q     <= 1'b0;
            AdrSrc     <= 1'b0;
            ResultSrc  <= 2'b00;
            ALUSrcA    <= 2'b00;
            ALUSrcB    <= 2'b00;
            ALUControl <= ALU_ADD;
            Busy       <= 1'b0;
        end else begin
            started    <= 1'b1;
            state      <= state_n;
            lane       <= lane_n;
            if (state == DECODE) vcond_q <= condex;
            IRWrite    <= c_n.irw;
            pcw_q      <= c_n.pcw;
            regw_q     <= c_n.regw & wr_ok & ~((state_n == ALUWB) & is_cmp);
            memw_q     <= c_n.memw;
            brw_q      <= c_n.brw;
            vecw_q     <= c_n.vecw & alu_ok;
            AdrSrc     <= c_n.adr_src;
            ResultSrc  <= c_n.result_src;
            ALUSrcA    <= c_n.alu_src_a;
            ALUSrcB    <= c_n.alu_src_b;
            ALUControl <= c_n.use_alu ? alu_dec : ALU_ADD;
            Busy       <= (state_n != FETCH);
        end
    end

    // Vector lanes use the condition latched in DECODE so mid-vector flag updates cannot cancel lanes.
    assign PCWrite  = pcw_q | (brw_q & condex);
    assign RegWrite = regw_q & condex;
    assign MemWrite = memw_q & condex;
    assign VecWrite = vecw_q & vcond_q;
    assign VecLane  = lane;
    assign ImmSrc   = op;
    assign RegSrc   = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

endmodule

// File: tb/tb_multicycle_vec_controller.sv
// Cycle-table bench for multicycle_vec_controller at VEC_LANES = 1, 4 and 16.
module tb_multicycle_vec_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] Instr = 20'h0;
    logic [3:0]  ALUFlags = 4'h0;

    always #5 clk = ~clk;

    logic       ir_w[3], pc_w[3], reg_w[3], mem_w[3], vec_w[3], adr_s[3], busy[3];
    logic [1:0] res_s[3], src_a[3], src_b[3], imm_s[3], reg_s[3];
    logic [2:0] alu_c[3];
    logic [0:0] lane1;
    logic [1:0] lane4;
    logic [3:0] lane16;

    multicycle_vec_controller #(.VEC_LANES(1)) dut1 (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .IRWrite(ir_w[0]), .PCWrite(pc_w[0]), .AdrSrc(adr_s[0]), .ResultSrc(res_s[0]),
        .ALUSrcA(src_a[0]), .ALUSrcB(src_b[0]), .ImmSrc(imm_s[0]), .RegSrc(reg_s[0]),
        .ALUControl(alu_c[0]), .RegWrite(reg_w[0]), .MemWrite(mem_w[0]),
        .VecWrite(vec_w[0]), .VecLane(lane1), .Busy(busy[0]));

    multicycle_vec_controller #(.VEC_LANES(4)) dut4 (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .IRWrite(ir_w[1]), .PCWrite(pc_w[1]), .AdrSrc(adr_s[1]), .ResultSrc(res_s[1]),
        .ALUSrcA(src_a[1]), .ALUSrcB(src_b[1]), .ImmSrc(imm_s[1]), .RegSrc(reg_s[1]),
        .ALUControl(alu_c[1]), .RegWrite(reg_w[1]), .MemWrite(mem_w[1]),
        .VecWrite(vec_w[1]), .VecLane(lane4), .Busy(busy[1]));

    multicycle_vec_controller #(.VEC_LANES(16)) dut16 (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .IRWrite(ir_w[2]), .PCWrite(pc_w[2]), .AdrSrc(adr_s[2]), .ResultSrc(res_s[2]),
        .ALUSrcA(src_a[2]), .ALUSrcB(src_b[2]), .ImmSrc(imm_s[2]), .RegSrc(reg_s[2]),
        .ALUControl(alu_c[2]), .RegWrite(reg_w[2]), .MemWrite(mem_w[2]),
        .VecWrite(vec_w[2]), .VecLane(lane16), .Busy(busy[2]));

    typedef struct {
        string       name;
        logic [19:0] instr;
        logic [3:0]  aluf;
        logic [4:0]  strb;   // {IRWrite, PCWrite, RegWrite, MemWrite, VecWrite}
        logic        busy;
        int          alu;    // -1: not checked
        int          lane;   // -1: not checked
        logic [6:0]  mux;    // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}
        logic [6:0]  mmask;
    } row_t;

    row_t tbl[$];
    row_t sb[$];
    int   checks = 0;
    int   passes = 0;

    localparam logic [19:0] I_ADDS = 20'hE0921;
    localparam logic [19:0] I_CMP  = 20'hE1510;
    localparam logic [19:0] I_BEQ  = 20'h0A000;
    localparam logic [19:0] I_ORRI = 20'hE3821;
    localparam logic [19:0] I_EOR  = 20'hE0221;
    localparam logic [19:0] I_NVADD = 20'hF0821;
    localparam logic [19:0] I_LDR  = 20'hE5921;
    localparam logic [19:0] I_STR  = 20'hE5821;
    localparam logic [19:0] I_VADD = 20'hEC810;
    localparam logic [19:0] I_VEQS = 20'h0C910;

    function automatic logic [19:0] obs(input int k);
        logic [3:0] ln;
        ln = (k == 0) ? {3'b000, lane1} : (k == 1) ? {2'b00, lane4} : lane16;
        return {ir_w[k], pc_w[k], reg_w[k], mem_w[k], vec_w[k], busy[k], alu_c[k],
                adr_s[k], res_s[k], src_a[k], src_b[k], ln};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic push_row(input string nm, input logic [19:0] ins, input logic [3:0] f,
                            input logic [4:0] s, input logic b, input int alu, input int lane,
                            input logic [6:0] mx, input logic [6:0] mk);
        row_t r;
        r.name = nm; r.instr = ins; r.aluf = f; r.strb = s; r.busy = b;
        r.alu = alu; r.lane = lane; r.mux = mx; r.mmask = mk;
        tbl.push_back(r);
    endtask

    task automatic add_f(input logic [19:0] ins);
        push_row("FETCH", ins, 4'h0, 5'b11000, 1'b0, 0, -1, 7'b0100110, 7'b1111111);
    endtask
    task automatic add_d(input logic [19:0] ins);
        push_row("DECODE", ins, 4'h0, 5'b00000, 1'b1, 0, -1, 7'b0000110, 7'b0001111);
    endtask
    task automatic add_v(input logic [19:0] ins, input logic [3:0] f, input int ln);
        push_row("VEXEC", ins, f, 5'b00001, 1'b1, -1, ln, 7'b0000000, 7'b0001111);
    endtask

    task automatic dp_instr(input string nm, input logic [19:0] ins, input logic [3:0] f,
                            input int alu, input logic regw);
        add_f(ins); add_d(ins);
        push_row({nm, "_exec"}, ins, f, 5'b00000, 1'b1, alu, -1, 7'b0, 7'b0);
        push_row({nm, "_aluwb"}, ins, 4'h0, {2'b00, regw, 2'b00}, 1'b1, -1, -1, 7'b0, 7'b0);
    endtask

    task automatic br_instr(input logic [19:0] ins, input logic pcw);
        add_f(ins); add_d(ins);
        push_row("BRANCH", ins, 4'h0, {1'b0, pcw, 3'b000}, 1'b1, -1, -1, 7'b0101001, 7'b0111111);
    endtask

    task automatic vec_instr(input logic [19:0] ins, input logic [3:0] f, input int n);
        add_f(ins); add_d(ins);
        for (int l = 0; l < n; l++) add_v(ins, f, l);
    endtask

    task automatic run_tbl(input int k);
        row_t e;
        logic [19:0] a;
        bit ok;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            Instr    = tbl[i].instr;
            ALUFlags = tbl[i].aluf;
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            a = obs(k);
            ok = (a[19:15] == e.strb) && (a[14] == e.busy) &&
                 (e.alu < 0 || a[13:11] == e.alu[2:0]) &&
                 ((a[10:4] & e.mmask) == (e.mux & e.mmask)) &&
                 (e.lane < 0 || a[3:0] == e.lane[3:0]);
            checks++;
            if (ok) passes++;
            else $display("FAIL %s row %0d dut%0d: got strb=%b busy=%b alu=%b mux=%b lane=%0d, expected strb=%b busy=%b alu=%0d mux=%b mask=%b lane=%0d",
                          e.name, i, k, a[19:15], a[14], a[13:11], a[10:4], a[3:0],
                          e.strb, e.busy, e.alu, e.mux, e.mmask, e.lane);
        end
        tbl.delete();
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        // Reset held for three cycles: no strobe and no Busy on any instance.
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk("reset_strobes", 32'(obs(k) >> 14), 32'h0);
        end
        @(posedge clk); #1 reset = 1'b1;

        dp_instr("adds", I_ADDS, 4'b0100, 0, 1'b1);
        br_instr(I_BEQ, 1'b1);
        dp_instr("cmp_z0", I_CMP, 4'b0000, 1, 1'b0);
        br_instr(I_BEQ, 1'b0);
        dp_instr("cmp_z1", I_CMP, 4'b0100, 1, 1'b0);
        br_instr(I_BEQ, 1'b1);
        vec_instr(I_VEQS, 4'b0000, 4);
        br_instr(I_BEQ, 1'b0);
        dp_instr("orri", I_ORRI, 4'b0000, 3, 1'b1);
        dp_instr("eor_unsup", I_EOR, 4'b0000, 0, 1'b0);
        dp_instr("nv_add", I_NVADD, 4'b0000, 0, 1'b0);
        add_f(I_LDR); add_d(I_LDR);
        push_row("LDR_MEMADR", I_LDR, 4'h0, 5'b00000, 1'b1, -1, -1, 7'b0, 7'b0);
        push_row("LDR_MEMRD", I_LDR, 4'h0, 5'b00000, 1'b1, -1, -1, 7'b0, 7'b0);
        push_row("LDR_MEMWB", I_LDR, 4'h0, 5'b00100, 1'b1, -1, -1, 7'b0010000, 7'b0110000);
        add_f(I_STR); add_d(I_STR);
        push_row("STR_MEMADR", I_STR, 4'h0, 5'b00000, 1'b1, -1, -1, 7'b0, 7'b0);
        push_row("STR_MEMWR", I_STR, 4'h0, 5'b00010, 1'b1, -1, -1, 7'b1000000, 7'b1000000);
        vec_instr(I_VADD, 4'b0000, 4);
        add_f(I_VADD); add_d(I_VADD);
        add_v(I_VADD, 4'h0, 0); add_v(I_VADD, 4'h0, 1);
        run_tbl(1);

        // Reset asserted mid-vector during lane 2.
        @(posedge clk);
        #2 chk("lane2_before_reset", {31'h0, vec_w[1]} << 2 | 32'(lane4), 32'h6);
        #1 reset = 1'b0;
        #1 chk("async_vecwrite_drop", {29'h0, vec_w[1], busy[1], ir_w[1]}, 32'h0);
        @(negedge clk) chk("reset_mid_strobes", 32'(obs(1) >> 14), 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_fetch", {24'h0, ir_w[1], pc_w[1], reg_w[1], mem_w[1], vec_w[1], busy[1], lane4},
            {24'h0, 5'b11000, 1'b0, 2'b00});

        reset_pulse();
        vec_instr(I_VADD, 4'h0, 1);
        add_f(I_ADDS);
        run_tbl(0);

        reset_pulse();
        vec_instr(I_VADD, 4'h0, 16);
        add_f(I_ADDS);
        run_tbl(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
